// File: rtl/exe_ctrl_pkg.sv
// Shared constants and types for the EXE hazard/forwarding controller.
package exe_ctrl_pkg;

  localparam int REG_IDX_W = 4;

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  typedef enum logic {ST_RUN, ST_MEM_WAIT} state_t;

  // The younger producer (EXE) wins over the older one (MEM).
  function automatic logic [1:0] pick_sel(input logic exe_hit, input logic mem_hit);
    if (exe_hit) return SEL_MEM;
    if (mem_hit) return SEL_WB;
    return SEL_REG;
  endfunction

endpackage

// File: rtl/fwd_compare.sv
// Compares one ID source index against the EXE and MEM destinations.
module fwd_compare
  import exe_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] src,
  input  logic                 used,
  input  logic [REG_IDX_W-1:0] exe_dest,
  input  logic                 exe_wb_en,
  input  logic [REG_IDX_W-1:0] mem_dest,
  input  logic                 mem_wb_en,
  output logic                 exe_hit,
  output logic                 mem_hit
);

  assign exe_hit = used && exe_wb_en && (exe_dest == src);
  assign mem_hit = used && mem_wb_en && (mem_dest == src);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// EXE-stage sequencing: load-use bubbles, memory-wait freeze and registered operand selects.
// Optional forwarding is enabled by defining HAZARD_FORWARD_EN; otherwise every RAW hazard stalls.
module hazard_forward_ctrl
  import exe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_src1,
  input  logic [REG_IDX_W-1:0] id_src2,
  input  logic                 id_two_src,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] exe_dest,
  input  logic                 exe_wb_en,
  input  logic                 exe_mem_r_en,
  input  logic [REG_IDX_W-1:0] mem_dest,
  input  logic                 mem_wb_en,
  input  logic                 mem_access,
  input  logic                 mem_ready,
  output logic [1:0]           sel_src1,
  output logic [1:0]           sel_src2,
  output logic                 hazard_stall,
  output logic                 freeze_all,
  output logic                 mem_timeout,
  output logic [CNT_W-1:0]     stall_count
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [REG_IDX_W-1:0] src_idx [2];
  logic [1:0]           src_used;
  logic [1:0]           exe_hit;
  logic [1:0]           mem_hit;

  state_t              state_reg;
  logic [WAIT_W-1:0]   wait_cnt_reg;
  logic                mem_timeout_reg;
  logic [CNT_W-1:0]    stall_count_reg;

  assign src_idx[0] = id_src1;
  assign src_idx[1] = id_src2;
  assign src_used   = {id_two_src, 1'b1};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cmp
      fwd_compare u_cmp (
        .src       (src_idx[gi]),
        .used      (src_used[gi]),
        .exe_dest  (exe_dest),
        .exe_wb_en (exe_wb_en),
        .mem_dest  (mem_dest),
        .mem_wb_en (mem_wb_en),
        .exe_hit   (exe_hit[gi]),
        .mem_hit   (mem_hit[gi])
      );
    end
  endgenerate

  // A zero-wait access completes in the same cycle and never freezes the pipe.
  assign freeze_all = mem_access && !mem_ready;

`ifdef HAZARD_FORWARD_EN
  logic [1:0] sel_src1_reg;
  logic [1:0] sel_src2_reg;

  assign hazard_stall = id_valid && exe_mem_r_en && (|exe_hit) && !freeze_all;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_src1_reg <= SEL_REG;
      sel_src2_reg <= SEL_REG;
    end else if (freeze_all) begin
      sel_src1_reg <= sel_src1_reg;
      sel_src2_reg <= sel_src2_reg;
    end else if (hazard_stall) begin
      sel_src1_reg <= SEL_REG;
      sel_src2_reg <= SEL_REG;
    end else begin
      sel_src1_reg <= pick_sel(exe_hit[0], mem_hit[0]);
      sel_src2_reg <= pick_sel(exe_hit[1], mem_hit[1]);
    end
  end

  assign sel_src1 = sel_src1_reg;
  assign sel_src2 = sel_src2_reg;
`else
  // Without forwarding a load is no different from any other producer.
  logic nofwd_unused;
  assign nofwd_unused = exe_mem_r_en;

  assign hazard_stall = id_valid && ((|exe_hit) || (|mem_hit)) && !freeze_all;
  assign sel_src1     = SEL_REG;
  assign sel_src2     = SEL_REG;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_RUN;
      wait_cnt_reg    <= '0;
      mem_timeout_reg <= 1'b0;
      stall_count_reg <= '0;
    end else begin
      case (state_reg)
        ST_RUN:      if (freeze_all) state_reg <= ST_MEM_WAIT;
        ST_MEM_WAIT: if (mem_ready)  state_reg <= ST_RUN;
        default:     state_reg <= ST_RUN;
      endcase

      // Counts consecutive frozen cycles; the flag rises on the MAX_WAIT-th one.
      if (freeze_all) begin
        if (wait_cnt_reg != WAIT_W'(MAX_WAIT))
          wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
        if (wait_cnt_reg >= WAIT_W'(MAX_WAIT - 1))
          mem_timeout_reg <= 1'b1;
      end else begin
        wait_cnt_reg <= '0;
      end

      if ((hazard_stall || freeze_all) && (stall_count_reg != '1))
        stall_count_reg <= stall_count_reg + CNT_W'(1);
    end
  end

  assign mem_timeout = mem_timeout_reg;
  assign stall_count = stall_count_reg;

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Sequences the EXE datapath: decides each cycle whether the instruction in ID may advance into EXE.
- Inserts load-use bubbles and freezes the whole pipe while the MEM stage waits on memory.
- Pre-computes and registers the EXE operand-source selects (Sel_src1/Sel_src2) for the instruction entering EXE.
- Sits beside the ID/EXE pipeline register; drives the EXE stage's select inputs and the pipeline freeze/flush controls.

Parameters:
- MAX_WAIT, 64: memory wait cycles before mem_timeout is raised.
- CNT_W, 16: width of the saturating stall performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_src1  in  4  Rn index of the instruction in ID.
- id_src2  in  4  Rm/Rd-store index of the instruction in ID.
- id_two_src  in  1  ID instruction reads id_src2 (register operand, no immediate, or a store).
- id_valid  in  1  ID holds a real instruction.
- exe_dest  in  4  destination register of the instruction in EXE.
- exe_wb_en  in  1  EXE instruction writes back.
- exe_mem_r_en  in  1  EXE instruction is a load.
- mem_dest  in  4  destination register of the instruction in MEM.
- mem_wb_en  in  1  MEM instruction writes back.
- mem_access  in  1  MEM instruction performs a read or write.
- mem_ready  in  1  memory completes this cycle.
- sel_src1  out  2  registered EXE src1 select.
- sel_src2  out  2  registered EXE src2 select.
- hazard_stall  out  1  hold PC and IF/ID; load a bubble into ID/EXE.
- freeze_all  out  1  hold every pipeline register.
- mem_timeout  out  1  sticky error flag.
- stall_count  out  CNT_W  count of cycles with hazard_stall or freeze_all high; saturates.

Behaviour:
- Select encoding:
  - 00 = register file value.
  - 01 = ALU_MEM_Val (the value becoming MEM-stage data next cycle).
  - 10 = WB_Val.
- Match definitions:
  - exe_hit(s): exe_wb_en && exe_dest == s.
  - mem_hit(s): mem_wb_en && mem_dest == s.
  - src2 matches are considered only when id_two_src = 1.
- FSM states:
  - RUN to MEM_WAIT when mem_access && !mem_ready.
  - MEM_WAIT to RUN when mem_ready.
  - RUN stays RUN otherwise.
- freeze_all:
  - Combinational: high when mem_access && !mem_ready, in either state.
  - Zero-wait accesses therefore never freeze.
- Wait counter:
  - Counts consecutive freeze cycles and clears on leaving MEM_WAIT.
  - When it reaches MAX_WAIT, mem_timeout sets.
  - mem_timeout stays set until rst.
  - The counter saturates at MAX_WAIT.
- hazard_stall:
  - Combinational: id_valid && exe_mem_r_en && (exe_hit(id_src1) || exe_hit(id_src2)) && !freeze_all.
  - freeze_all dominates: no bubble is inserted during a freeze.
- Select registers, updated on each clock edge:
  - freeze_all = 1: hold.
  - Else hazard_stall = 1: load 00/00 (bubble).
  - Else, per source: exe_hit gives 01; else mem_hit gives 10; else 00.
  - exe_hit has priority over mem_hit.
  - Result: the selects are valid in the same cycle the instruction occupies EXE (one-cycle latency from ID).
- Load-use sequence: one stall cycle. On the next cycle the load sits in MEM, so the re-evaluation yields mem_hit and a select of 10.
- Register 0 is not special; index 15 is treated like any other.
- stall_count increments by 1 per qualifying cycle and saturates at all-ones.
- Reset values:
  - sel_src1 = sel_src2 = 00.
  - state = RUN.
  - wait counter = 0, stall_count = 0, mem_timeout = 0.
- Reset mid-wait returns the FSM to RUN at once. Combinational outputs follow their inputs.

Optional Feature:
- Macro: HAZARD_FORWARD_EN.
- Defined: forwarding as described above.
- Undefined:
  - sel_src1/sel_src2 are constant 00.
  - hazard_stall = id_valid && (exe_hit or mem_hit on any used source) && !freeze_all.
  - Any RAW hazard against EXE or MEM stalls until the producer reaches WB.

Decomposition:
- Package exe_ctrl_pkg holds:
  - SEL_REG = 2'b00, SEL_MEM = 2'b01, SEL_WB = 2'b10.
  - State enum {ST_RUN, ST_MEM_WAIT}.
  - REG_IDX_W = 4.
- One sub-module, fwd_compare: a combinational source-vs-destination match producing the exe_hit/mem_hit pair. Instantiated once per source.

Test Plan:
- ADD writes r3 in EXE; ID reads r3 as src1, id_two_src = 0 -> next cycle sel_src1 = 01, hazard_stall = 0 throughout.
- LDR r4 in EXE; ID reads r4 as src2 with id_two_src = 1 -> hazard_stall = 1 for exactly 1 cycle, then sel_src2 = 10; stall_count = 1.
- exe_dest = mem_dest = r5, both wb_en, no load -> sel_src1 = 01 (EXE priority).
- mem_access with mem_ready low for 3 cycles during a load-use hazard -> freeze_all = 1 for 3 cycles, hazard_stall = 0, selects held; the stall follows after mem_ready; stall_count = 4.
- MAX_WAIT = 4, mem_ready held low for 6 cycles -> mem_timeout rises after the 4th wait cycle and stays high after mem_ready, until rst.
- rst asserted in MEM_WAIT -> next edge: state RUN, selects 00, counters 0, mem_timeout 0. Build without HAZARD_FORWARD_EN -> ADD r3 dependency stalls 2 cycles with selects 00.
